// File: rtl/counter_seq_ctrl_if.sv
// Command/counter-pin bundle between a command source, the up/down counter
// and the sequencer. The slave side is the sequencer.
interface counter_seq_ctrl_if #(
  parameter int W  = 4,
  parameter int PW = 4
);
  logic          start;
  logic [W-1:0]  start_val;
  logic [W-1:0]  end_val;
  logic [PW-1:0] passes;
  logic          pause;
  logic          abort;
  logic [W-1:0]  cnt_value;
  logic          cnt_en;
  logic          cnt_dir;
  logic          cnt_load;
  logic [W-1:0]  cnt_data;
  logic          busy;
  logic          done;
  logic [PW-1:0] pass_left;

  modport slave (
    input  start, start_val, end_val, passes, pause, abort, cnt_value,
    output cnt_en, cnt_dir, cnt_load, cnt_data, busy, done, pass_left
  );

  modport master (
    output start, start_val, end_val, passes, pause, abort, cnt_value,
    input  cnt_en, cnt_dir, cnt_load, cnt_data, busy, done, pass_left
  );
endinterface

// File: rtl/counter_seq_ctrl.sv
// Sequencer that loads an up/down counter and bounces it between two
// endpoints for a programmed number of passes, pulsing done at the end.
module counter_seq_ctrl #(
  parameter int W  = 4,
  parameter int PW = 4
) (
  input  logic               clk,
  input  logic               rst,
  counter_seq_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  s_q, s_d;
  logic [W-1:0]  e_q, e_d;
  logic [W-1:0]  tgt_q, tgt_d;
  logic          dir_q, dir_d;
  logic [PW-1:0] pass_left_q, pass_left_d;
  logic          at_tgt;

  assign at_tgt = (bus.cnt_value == tgt_q);

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    e_d         = e_q;
    tgt_d       = tgt_q;
    dir_d       = dir_q;
    pass_left_d = pass_left_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          s_d         = bus.start_val;
          e_d         = bus.end_val;
          tgt_d       = bus.end_val;
          dir_d       = (bus.end_val >= bus.start_val);
          pass_left_d = (bus.passes == '0) ? PW'(1) : bus.passes;
          state_d     = LOAD;
        end
      end
      LOAD: state_d = bus.abort ? IDLE : RUN;
      RUN: begin
        // abort outranks arrival; pause freezes all bookkeeping
        if (bus.abort) begin
          state_d = IDLE;
        end else if (!bus.pause && at_tgt) begin
          if (pass_left_q == PW'(1)) begin
            pass_left_d = '0;
            state_d     = DONE;
          end else begin
            pass_left_d = pass_left_q - PW'(1);
            tgt_d       = (tgt_q == e_q) ? s_q : e_q;
            dir_d       = ~dir_q;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      s_q         <= '0;
      e_q         <= '0;
      tgt_q       <= '0;
      dir_q       <= 1'b1;
      pass_left_q <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      e_q         <= e_d;
      tgt_q       <= tgt_d;
      dir_q       <= dir_d;
      pass_left_q <= pass_left_d;
    end
  end

  // Counter pins follow the state registers; RUN also looks at cnt_value so
  // the enable drops on the very cycle the target is reached.
  always_comb begin
    bus.cnt_en   = 1'b0;
    bus.cnt_load = 1'b0;
    bus.cnt_data = '0;
    bus.cnt_dir  = dir_q;
    bus.busy     = (state_q != IDLE);
    bus.done     = 1'b0;
    unique case (state_q)
      LOAD: begin
        bus.cnt_en   = ~bus.abort;
        bus.cnt_load = ~bus.abort;
        bus.cnt_data = s_q;
      end
      RUN:     bus.cnt_en = ~bus.abort & ~bus.pause & ~at_tgt;
      DONE:    bus.done   = ~bus.abort;
      default: ;
    endcase
  end

  assign bus.pass_left = pass_left_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench: drives the sequencer against a behavioural up/down counter
// and checks hand-derived cycle-by-cycle expectations.
module tb_counter_seq_ctrl;
  localparam int W  = 4;
  localparam int PW = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] cnt = '0;
  int           n_cmp = 0;
  int           n_err = 0;
  int           ndone;

  int seq_b [18] = '{8, 7, 6, 5, 4, 3, 3, 4, 5, 6, 7, 8, 8, 7, 6, 5, 4, 3};

  counter_seq_ctrl_if #(.W(W), .PW(PW)) bus ();

  counter_seq_ctrl #(.W(W), .PW(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.cnt_value = cnt;

  always @(posedge clk)
    if (bus.cnt_en)
      cnt <= bus.cnt_load ? bus.cnt_data : (bus.cnt_dir ? cnt + 4'd1 : cnt - 4'd1);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic go(input int s, input int e, input int p);
    bus.start_val = W'(s);
    bus.end_val   = W'(e);
    bus.passes    = PW'(p);
    bus.start     = 1'b1;
    tick;
    bus.start     = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.start_val = '0; bus.end_val = '0; bus.passes = '0;
    bus.pause = 1'b0; bus.abort = 1'b0;
    tick; tick;
    chk("rst_busy", bus.busy, 0);
    chk("rst_en", bus.cnt_en, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_load", bus.cnt_load, 0);
    chk("rst_data", bus.cnt_data, 0);
    chk("rst_dir", bus.cnt_dir, 1);
    chk("rst_pass", bus.pass_left, 0);
    rst = 1'b0;
    tick;

    // 2 -> 5, one pass
    go(2, 5, 1);
    chk("a_load", bus.cnt_load, 1);
    chk("a_en_ld", bus.cnt_en, 1);
    chk("a_data", bus.cnt_data, 2);
    chk("a_pass1", bus.pass_left, 1);
    tick;
    for (int i = 0; i < 4; i++) begin
      chk("a_val", cnt, 2 + i);
      chk("a_en", bus.cnt_en, (i < 3) ? 1 : 0);
      chk("a_nodone", bus.done, 0);
      tick;
    end
    chk("a_done", bus.done, 1);
    chk("a_busy_d", bus.busy, 1);
    chk("a_pass0", bus.pass_left, 0);
    chk("a_en_d", bus.cnt_en, 0);
    tick;
    chk("a_idle", bus.busy, 0);
    chk("a_done0", bus.done, 0);
    chk("a_hold", cnt, 5);

    // 8 -> 3, three passes
    go(8, 3, 3);
    chk("b_pass3", bus.pass_left, 3);
    chk("b_data", bus.cnt_data, 8);
    tick;
    ndone = 0;
    for (int c = 2; c <= 19; c++) begin
      chk("b_val", cnt, seq_b[c-2]);
      chk("b_pass", bus.pass_left, (c <= 7) ? 3 : ((c <= 13) ? 2 : 1));
      chk("b_dir", bus.cnt_dir, (c >= 8 && c <= 13) ? 1 : 0);
      if (bus.done) ndone++;
      tick;
    end
    chk("b_done", bus.done, 1);
    chk("b_pass0", bus.pass_left, 0);
    if (bus.done) ndone++;
    tick;
    chk("b_idle", bus.busy, 0);
    if (bus.done) ndone++;
    chk("b_ndone", ndone, 1);
    chk("b_hold", cnt, 3);

    // equal endpoints, passes=0
    go(7, 7, 0);
    chk("c_pass1", bus.pass_left, 1);
    chk("c_data", bus.cnt_data, 7);
    tick;
    chk("c_val", cnt, 7);
    chk("c_en", bus.cnt_en, 0);
    chk("c_nodone", bus.done, 0);
    tick;
    chk("c_done", bus.done, 1);
    tick;
    chk("c_idle", bus.busy, 0);

    // 2 -> 9 with a 4-cycle pause at value 4
    go(2, 9, 1);
    tick;
    chk("d_v2", cnt, 2);
    tick;
    chk("d_v3", cnt, 3);
    tick;
    for (int k = 0; k < 4; k++) begin
      if (k == 0) bus.pause = 1'b1;
      #1;
      chk("d_hold", cnt, 4);
      chk("d_en0", bus.cnt_en, 0);
      chk("d_nodone", bus.done, 0);
      tick;
    end
    bus.pause = 1'b0;
    #1;
    chk("d_rel", cnt, 4);
    chk("d_en1", bus.cnt_en, 1);
    tick;
    for (int v = 5; v <= 9; v++) begin
      chk("d_val", cnt, v);
      chk("d_nodone2", bus.done, 0);
      tick;
    end
    chk("d_done", bus.done, 1);
    tick;
    chk("d_idle", bus.busy, 0);

    // abort at 6 after a start pulse while busy
    go(3, 10, 2);
    tick;
    chk("e_v3", cnt, 3);
    tick;
    bus.start_val = 4'd0; bus.end_val = 4'd1; bus.passes = 4'd5;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    bus.start_val = 4'd3; bus.end_val = 4'd10; bus.passes = 4'd2;
    chk("e_v5", cnt, 5);
    chk("e_pass", bus.pass_left, 2);
    chk("e_dir", bus.cnt_dir, 1);
    chk("e_en", bus.cnt_en, 1);
    tick;
    chk("e_v6", cnt, 6);
    bus.abort = 1'b1;
    #1;
    chk("e_ab_en", bus.cnt_en, 0);
    chk("e_ab_done", bus.done, 0);
    chk("e_ab_busy", bus.busy, 1);
    tick;
    bus.abort = 1'b0;
    chk("e_idle", bus.busy, 0);
    chk("e_nodone", bus.done, 0);
    chk("e_hold", cnt, 6);
    chk("e_pass2", bus.pass_left, 2);
    tick;
    chk("e_hold2", cnt, 6);
    chk("e_nodone2", bus.done, 0);

    // asynchronous reset in the middle of RUN
    go(2, 9, 1);
    tick; tick; tick;
    chk("r_v4", cnt, 4);
    chk("r_busy1", bus.busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("r_busy", bus.busy, 0);
    chk("r_en", bus.cnt_en, 0);
    chk("r_done", bus.done, 0);
    chk("r_pass", bus.pass_left, 0);
    chk("r_dir", bus.cnt_dir, 1);
    tick;
    rst = 1'b0;
    tick;
    chk("r_nodone", bus.done, 0);
    chk("r_idle", bus.busy, 0);
    chk("r_hold", cnt, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
